// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: operand-select encodings and
// the branch-penalty FSM state type.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam int STALL_CNT_W = 16;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } br_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX/MEM/WB register info in,
// stall and forwarding controls out.
interface hazard_ctrl_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2
);
    import hazard_ctrl_pkg::*;

    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic                     id_is_branch;
    logic [REG_W-1:0]         ex_rw;
    logic [REG_W-1:0]         mem_rw;
    logic [REG_W-1:0]         wb_rw;
    logic                     ex_regwr;
    logic                     mem_regwr;
    logic                     wb_regwr;
    logic                     ex_is_load;
    logic                     if_stall;
    logic                     id_stall;
    logic [2*NUM_SRC-1:0]     fwd_sel;
    logic [STALL_CNT_W-1:0]   stall_cnt;

    modport master (
        output id_src, id_src_used, id_is_branch,
        output ex_rw, mem_rw, wb_rw, ex_regwr, mem_regwr, wb_regwr, ex_is_load,
        input  if_stall, id_stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_src, id_src_used, id_is_branch,
        input  ex_rw, mem_rw, wb_rw, ex_regwr, mem_regwr, wb_regwr, ex_is_load,
        output if_stall, id_stall, fwd_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_reg_match.sv
// One source-vs-destination comparator; register 0 is hardwired and never
// produces a dependency.
module reg_match #(
    parameter int REG_W = 5
) (
    input  logic             i_used,
    input  logic             i_regwr,
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_rw,
    output logic             o_match
);

    assign o_match = i_used & i_regwr & (i_src == i_rw) & (i_rw != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-dependency stall/forward selection, fixed
// branch IF penalty FSM and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_EN     = 1,
    parameter int BR_PENALTY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam logic [3:0]             BR_LOAD  = 4'(BR_PENALTY - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_SRC-1:0]     w_m_ex;
    logic [NUM_SRC-1:0]     w_m_mem;
    logic [NUM_SRC-1:0]     w_m_wb;
    logic [2*NUM_SRC-1:0]   w_fwd_sel;
    logic                   w_data_stall;
    logic                   w_br_stall;
    logic                   w_if_stall;

    br_state_e              r_state;
    br_state_e              w_state_nxt;
    logic [3:0]             r_br_cnt;
    logic [3:0]             w_br_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        reg_match #(.REG_W(REG_W)) u_m_ex (
            .i_used  (bus.id_src_used[g]),
            .i_regwr (bus.ex_regwr),
            .i_src   (bus.id_src[g*REG_W +: REG_W]),
            .i_rw    (bus.ex_rw),
            .o_match (w_m_ex[g])
        );
        reg_match #(.REG_W(REG_W)) u_m_mem (
            .i_used  (bus.id_src_used[g]),
            .i_regwr (bus.mem_regwr),
            .i_src   (bus.id_src[g*REG_W +: REG_W]),
            .i_rw    (bus.mem_rw),
            .o_match (w_m_mem[g])
        );
        reg_match #(.REG_W(REG_W)) u_m_wb (
            .i_used  (bus.id_src_used[g]),
            .i_regwr (bus.wb_regwr),
            .i_src   (bus.id_src[g*REG_W +: REG_W]),
            .i_rw    (bus.wb_rw),
            .o_match (w_m_wb[g])
        );
    end

    // Youngest producer wins; only a load in EX cannot be bypassed in time.
    always_comb begin
        w_fwd_sel    = '0;
        w_data_stall = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (FWD_EN != 0) begin
                if (w_m_ex[k]) begin
                    w_fwd_sel[2*k +: 2] = FWD_EX;
                    if (bus.ex_is_load) w_data_stall = 1'b1;
                end else if (w_m_mem[k]) begin
                    w_fwd_sel[2*k +: 2] = FWD_MEM;
                end else if (w_m_wb[k]) begin
                    w_fwd_sel[2*k +: 2] = FWD_WB;
                end
            end else if (w_m_ex[k] | w_m_mem[k] | w_m_wb[k]) begin
                w_data_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_br_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_br_cnt <= w_br_cnt_nxt;
        end
    end

    // The triggering cycle is the first penalty cycle, so BR_WAIT lasts
    // BR_PENALTY-1 cycles and exits once the decremented count reaches zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_br_cnt_nxt = r_br_cnt;
        w_br_stall   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.id_is_branch && !w_data_stall) begin
                    w_br_stall   = 1'b1;
                    w_br_cnt_nxt = BR_LOAD;
                    w_state_nxt  = (BR_PENALTY > 1) ? ST_BR_WAIT : ST_RUN;
                end
            end
            ST_BR_WAIT: begin
                w_br_stall   = 1'b1;
                w_br_cnt_nxt = (r_br_cnt == 4'd0) ? 4'd0 : r_br_cnt - 4'd1;
                if (r_br_cnt <= 4'd1) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_br_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign w_if_stall = w_br_stall | w_data_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_if_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.if_stall  = w_if_stall;
    assign bus.id_stall  = w_data_stall;
    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a stall-only instance share
// stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int NUM_SRC = 2;
    localparam int BRP     = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_SRC*REG_W-1:0] t_src = '0;
    logic [NUM_SRC-1:0]       t_used = '0;
    logic                     t_br = 1'b0;
    logic [REG_W-1:0]         t_ex_rw = '0, t_mem_rw = '0, t_wb_rw = '0;
    logic                     t_ex_wr = 1'b0, t_mem_wr = 1'b0, t_wb_wr = 1'b0;
    logic                     t_load = 1'b0;

    hazard_ctrl_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC)) if_f ();
    hazard_ctrl_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC)) if_s ();

    assign if_f.id_src = t_src;        assign if_s.id_src = t_src;
    assign if_f.id_src_used = t_used;  assign if_s.id_src_used = t_used;
    assign if_f.id_is_branch = t_br;   assign if_s.id_is_branch = t_br;
    assign if_f.ex_rw = t_ex_rw;       assign if_s.ex_rw = t_ex_rw;
    assign if_f.mem_rw = t_mem_rw;     assign if_s.mem_rw = t_mem_rw;
    assign if_f.wb_rw = t_wb_rw;       assign if_s.wb_rw = t_wb_rw;
    assign if_f.ex_regwr = t_ex_wr;    assign if_s.ex_regwr = t_ex_wr;
    assign if_f.mem_regwr = t_mem_wr;  assign if_s.mem_regwr = t_mem_wr;
    assign if_f.wb_regwr = t_wb_wr;    assign if_s.wb_regwr = t_wb_wr;
    assign if_f.ex_is_load = t_load;   assign if_s.ex_is_load = t_load;

    hazard_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_EN(1), .BR_PENALTY(BRP)) u_fwd (
        .clk(clk), .rst_n(rst_n), .bus(if_f.slave)
    );
    hazard_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .FWD_EN(0), .BR_PENALTY(BRP)) u_stl (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave)
    );

    int checks = 0;
    int errors = 0;
    // Model: remaining branch-penalty cycles after the current one, and counts.
    int rem_f = 0, rem_s = 0;
    int cnt_f = 0, cnt_s = 0;
    logic last_if_f;
    int if_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int src_of(input int i);
        return int'((t_src >> (i*REG_W)) & ((1 << REG_W) - 1));
    endfunction

    function automatic bit hit(input int i, input int rw, input bit wr);
        return t_used[i] && wr && (src_of(i) == rw) && (rw != 0);
    endfunction

    task automatic clear_inputs();
        t_src = '0; t_used = '0; t_br = 1'b0; t_load = 1'b0;
        t_ex_rw = '0; t_mem_rw = '0; t_wb_rw = '0;
        t_ex_wr = 1'b0; t_mem_wr = 1'b0; t_wb_wr = 1'b0;
    endtask

    task automatic tick(input bit do_chk);
        int sel;
        logic [3:0] e_fwd;
        bit e_idf, e_ids, e_iff, e_ifs;
        #1;
        e_fwd = '0; e_idf = 1'b0; e_ids = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel = 0;
            if (hit(i, int'(t_ex_rw), t_ex_wr)) begin
                sel = 1;
                if (t_load) e_idf = 1'b1;
            end else if (hit(i, int'(t_mem_rw), t_mem_wr)) sel = 2;
            else if (hit(i, int'(t_wb_rw), t_wb_wr)) sel = 3;
            if (sel != 0) e_ids = 1'b1;
            e_fwd[2*i +: 2] = 2'(sel);
        end
        e_iff = e_idf || (rem_f > 0) || t_br;
        e_ifs = e_ids || (rem_s > 0) || t_br;
        last_if_f = if_f.if_stall;
        if (do_chk) begin
            chk("fwd.id_stall",  32'(if_f.id_stall),  32'(e_idf));
            chk("fwd.if_stall",  32'(if_f.if_stall),  32'(e_iff));
            chk("fwd.fwd_sel",   32'(if_f.fwd_sel),   32'(e_fwd));
            chk("fwd.stall_cnt", 32'(if_f.stall_cnt), 32'(cnt_f));
            chk("stl.id_stall",  32'(if_s.id_stall),  32'(e_ids));
            chk("stl.if_stall",  32'(if_s.if_stall),  32'(e_ifs));
            chk("stl.fwd_sel",   32'(if_s.fwd_sel),   32'd0);
            chk("stl.stall_cnt", 32'(if_s.stall_cnt), 32'(cnt_s));
        end
        if (rem_f > 0) rem_f--; else if (t_br && !e_idf) rem_f = BRP - 1;
        if (rem_s > 0) rem_s--; else if (t_br && !e_ids) rem_s = BRP - 1;
        if (e_iff && cnt_f < 65535) cnt_f++;
        if (e_ifs && cnt_s < 65535) cnt_s++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with quiet inputs.
        clear_inputs();
        #2;
        chk("rst.fwd.if_stall",  32'(if_f.if_stall),  32'd0);
        chk("rst.fwd.stall_cnt", 32'(if_f.stall_cnt), 32'd0);
        chk("rst.stl.id_stall",  32'(if_s.id_stall),  32'd0);
        chk("rst.stl.stall_cnt", 32'(if_s.stall_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1);

        // Load-use on source 0.
        t_ex_rw = 5'd5; t_ex_wr = 1'b1; t_load = 1'b1;
        t_src = {5'd0, 5'd5}; t_used = 2'b01;
        #1;
        chk("loaduse.id_stall", 32'(if_f.id_stall), 32'd1);
        chk("loaduse.if_stall", 32'(if_f.if_stall), 32'd1);
        tick(1);
        chk("loaduse.cnt_inc", 32'(if_f.stall_cnt), 32'd1);
        clear_inputs();

        // Forward priority on source 1.
        t_ex_rw = 5'd7; t_mem_rw = 5'd7; t_wb_rw = 5'd7;
        t_ex_wr = 1'b1; t_mem_wr = 1'b1; t_wb_wr = 1'b1;
        t_src = {5'd7, 5'd0}; t_used = 2'b10;
        #1;
        chk("prio.fwd_sel_hi", 32'(if_f.fwd_sel[3:2]), 32'd1);
        chk("prio.id_stall",   32'(if_f.id_stall),     32'd0);
        tick(1);
        clear_inputs();

        // Register 0 never matches; then a WB dependency.
        t_src = '0; t_used = 2'b01; t_ex_rw = '0; t_ex_wr = 1'b1;
        #1;
        chk("r0.stl.id_stall", 32'(if_s.id_stall), 32'd0);
        tick(1);
        t_src = {5'd0, 5'd3}; t_wb_rw = 5'd3; t_wb_wr = 1'b1;
        #1;
        chk("wb.stl.id_stall", 32'(if_s.id_stall), 32'd1);
        chk("wb.fwd.fwd_sel",  32'(if_f.fwd_sel),  32'd3);
        tick(1);
        clear_inputs();

        // Branch pulse, plus a retrigger attempt during BR_WAIT.
        if_cycles = 0;
        t_br = 1'b1; tick(1); if_cycles += int'(last_if_f);
        t_br = 1'b0; tick(1); if_cycles += int'(last_if_f);
        t_br = 1'b1; tick(1); if_cycles += int'(last_if_f);
        t_br = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1); if_cycles += int'(last_if_f);
        end
        chk("branch.if_len", 32'(if_cycles), 32'(BRP));

        // Reset asserted in the second BR_WAIT cycle.
        t_br = 1'b1; tick(1);
        t_br = 1'b0; tick(1);
        rst_n = 1'b0;
        #1;
        chk("midrst.fwd.if_stall",  32'(if_f.if_stall),  32'd0);
        chk("midrst.fwd.stall_cnt", 32'(if_f.stall_cnt), 32'd0);
        chk("midrst.stl.stall_cnt", 32'(if_s.stall_cnt), 32'd0);
        rem_f = 0; rem_s = 0; cnt_f = 0; cnt_s = 0;
        rst_n = 1'b1;
        tick(1);
        tick(1);

        // Randomized traffic over a small register range to provoke matches.
        for (int n = 0; n < 400; n++) begin
            t_src    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            t_used   = 2'($urandom);
            t_ex_rw  = 5'($urandom_range(0, 7));
            t_mem_rw = 5'($urandom_range(0, 7));
            t_wb_rw  = 5'($urandom_range(0, 7));
            t_ex_wr  = 1'($urandom); t_mem_wr = 1'($urandom); t_wb_wr = 1'($urandom);
            t_load   = 1'($urandom);
            t_br     = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        clear_inputs();
        tick(1);

        // Saturation under a sustained load-use stall.
        t_ex_rw = 5'd9; t_ex_wr = 1'b1; t_load = 1'b1;
        t_src = {5'd0, 5'd9}; t_used = 2'b01;
        for (int n = 0; n < 70000; n++) tick(0);
        tick(1);
        chk("sat.fwd.stall_cnt", 32'(if_f.stall_cnt), 32'hFFFF);
        tick(1);
        chk("sat.hold.stall_cnt", 32'(if_f.stall_cnt), 32'hFFFF);
        chk("sat.stl.stall_cnt",  32'(if_s.stall_cnt), 32'hFFFF);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
